// File: rtl/wrr_router_pkg.sv
// Shared helpers for the weighted round-robin router: weight and destination
// field extraction, plus a constant-safe clog2.
package wrr_router_pkg;

    localparam int MAX_CH = 16;
    localparam int WT_W   = 4;

    function automatic int clog2_c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // A zero weight still grants one word, so no channel can be starved by config.
    function automatic logic [WT_W-1:0] eff_weight(input logic [WT_W*MAX_CH-1:0] weights,
                                                   input int c);
        logic [WT_W-1:0] w;
        w = weights[WT_W*c +: WT_W];
        return (w == '0) ? WT_W'(1) : w;
    endfunction

    function automatic logic [3:0] dest_of(input logic [63:0] word, input int lsb, input int w);
        logic [63:0] m;
        m = (word >> lsb) & ((64'd1 << w) - 64'd1);
        return m[3:0];
    endfunction

endpackage

// File: rtl/wrr_router_pick.sv
// Rotating-priority picker: first set elig bit at or above ptr, wrapping.
// N_CH must be a power of two so the index add wraps for free.
module wrr_pick
    import wrr_router_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = clog2_c(N_CH)
) (
    input  logic [N_CH-1:0]  elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] c;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        c     = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = ptr + IDX_W'(i);
            if (!valid && elig[c]) begin
                valid = 1'b1;
                idx   = c;
            end
        end
        if (valid) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/wrr_router.sv
// Weighted round-robin referee: pops one FWFT input head per cycle and routes
// it to the output FIFO named by its destination field, one cycle later.
module wrr_router
    import wrr_router_pkg::*;
#(
    parameter int              N_CH     = 4,
    parameter int              DATA_W   = 12,
    parameter int              DEST_LSB = 8,
    parameter int              DEST_W   = clog2_c(N_CH),
    parameter logic [N_CH*4-1:0] WEIGHTS = {4'd1, 4'd2, 4'd3, 4'd4}
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     enable,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          empty,
    input  logic [N_CH-1:0]          almost_full,
    output logic [N_CH-1:0]          pop,
    output logic [N_CH-1:0]          push,
    output logic [DATA_W-1:0]        data_out,
    output logic                     idle
);

    localparam logic [WT_W*MAX_CH-1:0] W_ALL = 64'(WEIGHTS);

    logic [N_CH-1:0][DATA_W-1:0] head;
    logic [N_CH-1:0][DEST_W-1:0] dest;
    logic [N_CH-1:0]             elig;
    logic [N_CH-1:0]             gnt_oh;
    logic [DEST_W-1:0]           ptr, gnt_idx, nxt_idx;
    logic [WT_W-1:0]             credit, base, rem;
    logic                        gnt_vld, in_flight;

    // Per-channel head decode; a head is held only if its own target is almost full.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign head[c] = in_data[DATA_W*c +: DATA_W];
        assign dest[c] = DEST_W'(dest_of(64'(head[c]), DEST_LSB, DEST_W));
        assign elig[c] = enable & ~empty[c] & ~almost_full[dest[c]];
    end

    wrr_pick #(.N_CH(N_CH), .IDX_W(DEST_W)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .valid (gnt_vld)
    );

    assign pop = reset_L ? gnt_oh : '0;

    // Winning away from ptr starts a fresh burst; ptr's leftover credit is forfeited.
    assign base    = (gnt_idx == ptr) ? credit : eff_weight(W_ALL, int'(gnt_idx));
    assign rem     = base - WT_W'(1);
    assign nxt_idx = gnt_idx + DEST_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr       <= '0;
            credit    <= eff_weight(W_ALL, 0);
            push      <= '0;
            data_out  <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= gnt_vld;
            push      <= gnt_vld ? (N_CH'(1) << dest[gnt_idx]) : '0;
            if (gnt_vld) begin
                data_out <= head[gnt_idx];
                if (rem == '0) begin
                    ptr    <= nxt_idx;
                    credit <= eff_weight(W_ALL, int'(nxt_idx));
                end else begin
                    ptr    <= gnt_idx;
                    credit <= rem;
                end
            end
        end
    end

    assign idle = &empty & ~in_flight;

endmodule
